// File: rtl/kv32_mmio_uart_tx_if.sv
// Data-memory bus port for the MMIO UART transmitter.
`timescale 1ns/1ps
interface kv32_mmio_uart_tx_if;
   logic        en;
   logic [3:0]  we;
   logic [31:0] addr;
   logic [31:0] din;
   logic [31:0] dout;

   modport master (output en, output we, output addr, output din, input dout);
   modport slave  (input en, input we, input addr, input din, output dout);
endinterface

// File: rtl/kv32_mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus-writable TX FIFO drained by a serialiser
// with a programmable bit period (DIV+1 clock cycles per bit).
`timescale 1ns/1ps
module kv32_mmio_uart_tx #(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter logic [15:0] DIV_INIT   = 16'd867
) (
   input  logic                 clk,
   input  logic                 rst,
   kv32_mmio_uart_tx_if.slave   bus,
   output logic                 txd
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   logic [7:0]    fifo_q [FIFO_DEPTH];
   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, level;
   logic          full, empty, push, push_req, pop;
   logic          ovf_q, ovf_d;
   logic [15:0]   div_q, div_d;
   logic [1:0]    state_q, state_d;
   logic [15:0]   bitcnt_q, bitcnt_d;
   logic [2:0]    bitidx_q, bitidx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          txd_q, txd_d;
   logic [31:0]   dout_q, status, rdata;
   logic          rd_en;
   logic          unused_bits;

   assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.din[31:16], bus.we[3:2]};

   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign empty = (wptr_q == rptr_q);
   assign level = wptr_q - rptr_q;

   assign rd_en    = bus.en && (bus.we == 4'b0000);
   assign push_req = bus.en && (bus.addr[3:2] == 2'd0) && bus.we[0];
   // Fullness is judged on the registered pointers, before any same-cycle pop.
   assign push     = push_req && !full;
   assign wptr_d   = wptr_q + {{AW{1'b0}}, push};
   assign rptr_d   = rptr_q + {{AW{1'b0}}, pop};

   // Register-side next state: sticky overflow and byte-enabled divisor.
   always_comb begin
      ovf_d = ovf_q;
      div_d = div_q;
      if (push_req && full) ovf_d = 1'b1;
      if (bus.en && (bus.addr[3:2] == 2'd1) && bus.we[0] && bus.din[3]) ovf_d = 1'b0;
      if (bus.en && (bus.addr[3:2] == 2'd2)) begin
         if (bus.we[0]) div_d[7:0]  = bus.din[7:0];
         if (bus.we[1]) div_d[15:8] = bus.din[15:8];
      end
   end

   // Status word and read-data mux.
   always_comb begin
      status          = '0;
      status[0]       = (state_q != ST_IDLE);
      status[1]       = full;
      status[2]       = empty;
      status[3]       = ovf_q;
      status[8 +: PW] = level;
      case (bus.addr[3:2])
         2'd1:    rdata = status;
         2'd2:    rdata = {16'h0000, div_q};
         default: rdata = '0;
      endcase
   end

   // Serialiser FSM next state; the bit timer reloads from the live divisor.
   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      bitidx_d = bitidx_q;
      shreg_d  = shreg_q;
      pop      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!empty) begin
               pop      = 1'b1;
               shreg_d  = fifo_q[rptr_q[AW-1:0]];
               bitcnt_d = div_q;
               state_d  = ST_START;
            end
         end
         ST_START: begin
            if (bitcnt_q == 16'd0) begin
               bitcnt_d = div_q;
               bitidx_d = 3'd0;
               state_d  = ST_DATA;
            end else begin
               bitcnt_d = bitcnt_q - 16'd1;
            end
         end
         ST_DATA: begin
            if (bitcnt_q == 16'd0) begin
               bitcnt_d = div_q;
               if (bitidx_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  bitidx_d = bitidx_q + 3'd1;
                  shreg_d  = {1'b0, shreg_q[7:1]};
               end
            end else begin
               bitcnt_d = bitcnt_q - 16'd1;
            end
         end
         default: begin
            if (bitcnt_q == 16'd0) begin
               // Back-to-back frames: go straight to the next start bit.
               if (!empty) begin
                  pop      = 1'b1;
                  shreg_d  = fifo_q[rptr_q[AW-1:0]];
                  bitcnt_d = div_q;
                  state_d  = ST_START;
               end else begin
                  state_d  = ST_IDLE;
               end
            end else begin
               bitcnt_d = bitcnt_q - 16'd1;
            end
         end
      endcase
   end

   // Line level follows the current state, so txd lags the state by one cycle.
   always_comb begin
      case (state_q)
         ST_START: txd_d = 1'b0;
         ST_DATA:  txd_d = shreg_q[0];
         default:  txd_d = 1'b1;
      endcase
   end

   // FIFO storage; contents need no reset since the pointers define validity.
   always_ff @(posedge clk) begin
      if (push) fifo_q[wptr_q[AW-1:0]] <= bus.din[7:0];
   end

   // All control state, with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         ovf_q    <= 1'b0;
         div_q    <= DIV_INIT;
         state_q  <= ST_IDLE;
         bitcnt_q <= '0;
         bitidx_q <= '0;
         shreg_q  <= '0;
         txd_q    <= 1'b1;
         dout_q   <= '0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         ovf_q    <= ovf_d;
         div_q    <= div_d;
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         bitidx_q <= bitidx_d;
         shreg_q  <= shreg_d;
         txd_q    <= txd_d;
         if (rd_en) dout_q <= rdata;
      end
   end

   assign bus.dout = dout_q;
   assign txd      = txd_q;

endmodule

// File: tb/tb_kv32_mmio_uart_tx.sv
// Directed bench for kv32_mmio_uart_tx: register map, framing, overflow, back-to-back
// frames and mid-frame reset.
`timescale 1ns/1ps
module tb_kv32_mmio_uart_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        txd;
   int unsigned n_cmp  = 0;
   int unsigned n_fail = 0;

   kv32_mmio_uart_tx_if bus ();

   kv32_mmio_uart_tx #(
      .FIFO_DEPTH (16),
      .DIV_INIT   (16'd867)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave),
      .txd (txd)
   );

   always #5 clk = ~clk;

   initial begin
      #900_000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; the access is taken at the following posedge.
   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
      bus.en   = 1'b1;
      bus.we   = w;
      bus.addr = a;
      bus.din  = d;
      @(negedge clk);
      bus.en   = 1'b0;
      bus.we   = 4'b0000;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      bus.en   = 1'b1;
      bus.we   = 4'b0000;
      bus.addr = a;
      @(negedge clk);
      bus.en   = 1'b0;
      d        = bus.dout;
   endtask

   logic [9:0]  f55  = 10'b10_1010_1010;
   logic [19:0] fpair = 20'b1001_1110_0011_0100_1010;
   logic [31:0] v;
   logic        saw_low;

   initial begin
      bus.en   = 1'b0;
      bus.we   = 4'b0000;
      bus.addr = '0;
      bus.din  = '0;

      #1 rst = 1'b0;
      #10;
      check("txd_in_reset", {31'd0, txd}, 32'h1);
      check("dout_in_reset", bus.dout, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("txd_after_reset", {31'd0, txd}, 32'h1);

      // Register map after reset.
      rd(32'h8, v);           check("div_reset", v, 32'h0000_0363);
      rd(32'hC, v);           check("unmapped_read", v, 32'h0);
      rd(32'h4, v);           check("status_reset", v, 32'h0000_0004);
      rd(32'h0, v);           check("txdata_read", v, 32'h0);
      rd(32'h1000_0008, v);   check("div_alias_high_addr", v, 32'h0000_0363);

      // Low-byte-only divisor write; upper half reads zero.
      wr(32'h8, 32'hFFFF_AA11, 4'b0001);
      check("dout_held_on_write", bus.dout, 32'h0000_0363);
      rd(32'h8, v);           check("div_byte_enable", v, 32'h0000_0311);

      // DIV=3, single frame 0x55: each bit held 4 cycles.
      wr(32'h8, 32'h3, 4'b0011);
      wr(32'h0, 32'h55, 4'b0001);
      @(negedge clk);
      check("txd_idle_before_start", {31'd0, txd}, 32'h1);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         check($sformatf("frame55_c%0d", i), {31'd0, txd}, {31'd0, f55[i/4]});
      end
      rd(32'h4, v);           check("status_after_frame", v, 32'h0000_0004);

      // DIV=100, 18 consecutive pushes: one popped, 16 stored, last dropped.
      wr(32'h8, 32'd100, 4'b0011);
      for (int k = 0; k < 18; k++) wr(32'h0, k, 4'b0001);
      rd(32'h4, v);           check("status_overflow", v, 32'h0000_100B);
      wr(32'h4, 32'h8, 4'b0001);
      rd(32'h4, v);           check("status_ovf_cleared", v, 32'h0000_1003);
      wr(32'h0, 32'h77, 4'b0010);
      rd(32'h4, v);           check("status_no_push_we1", v, 32'h0000_1003);

      // Drain quickly with DIV=0.
      wr(32'h8, 32'h0, 4'b0011);
      v = '0;
      for (int i = 0; i < 2000; i++) begin
         rd(32'h4, v);
         if (v == 32'h4) break;
      end
      check("drain_done", v, 32'h0000_0004);
      repeat (3) @(negedge clk);

      // DIV=0, two back-to-back frames with no idle gap.
      wr(32'h0, 32'hA5, 4'b0001);
      wr(32'h0, 32'h3C, 4'b0001);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check($sformatf("pair_c%0d", i), {31'd0, txd}, {31'd0, fpair[i]});
      end
      @(negedge clk);
      check("txd_idle_after_pair", {31'd0, txd}, 32'h1);
      rd(32'h4, v);           check("status_after_pair", v, 32'h0000_0004);

      // Reset during the data bits of a 0x00 frame.
      wr(32'h8, 32'h3, 4'b0011);
      wr(32'h0, 32'h00, 4'b0001);
      repeat (10) @(negedge clk);
      check("txd_low_in_data", {31'd0, txd}, 32'h0);
      #1 rst = 1'b0;
      #1;
      check("txd_async_reset", {31'd0, txd}, 32'h1);
      check("dout_async_reset", bus.dout, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rd(32'h4, v);           check("status_after_midreset", v, 32'h0000_0004);
      rd(32'h8, v);           check("div_after_midreset", v, 32'h0000_0363);
      saw_low = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (txd !== 1'b1) saw_low = 1'b1;
      end
      check("no_frame_after_reset", {31'd0, saw_low}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
